// File: rtl/cp0_trap_sequencer.sv
// CP0 trap sequencer: turns CP0 interrupt/ERET events into pipeline flushes
// and a PC redirect, and tracks handler nesting depth.
module cp0_trap_sequencer #(
    parameter logic [31:0] VEC_BASE  = 32'h0000_0800,
    parameter int unsigned VEC_SHIFT = 4,
    parameter int unsigned DEPTH_W   = 3
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               int_req_i,
    input  logic [2:0]         ipservice_i,
    input  logic               eret_i,
    input  logic [31:0]        epc_i,
    input  logic               stall_i,
    output logic               flush_if_id_o,
    output logic               flush_id_ex_o,
    output logic               pc_load_o,
    output logic [31:0]        pc_target_o,
    output logic               in_handler_o,
    output logic [DEPTH_W-1:0] depth_o,
    output logic               nest_err_o
);

    typedef enum logic [1:0] {StIdle, StIntWait, StIntLoad, StRetLoad} state_e;

    localparam logic [DEPTH_W-1:0] DepthMax = '1;

    state_e             state_q, state_d;
    logic               flush_if_id_q, flush_if_id_d;
    logic               flush_id_ex_q, flush_id_ex_d;
    logic               pc_load_q, pc_load_d;
    logic [31:0]        pc_target_q, pc_target_d;
    logic               in_handler_q, in_handler_d;
    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic               nest_err_q, nest_err_d;

    logic [31:0]        vec_idx;
    logic [31:0]        vec_addr;

    // Handler vector from the in-service bits; highest set bit wins, none = spurious slot 0.
    always_comb begin
        vec_idx = 32'd0;
        if (ipservice_i[2]) begin
            vec_idx = 32'd3;
        end else if (ipservice_i[1]) begin
            vec_idx = 32'd2;
        end else if (ipservice_i[0]) begin
            vec_idx = 32'd1;
        end
        vec_addr = VEC_BASE + (vec_idx << VEC_SHIFT);
    end

    // Next state and next registered outputs; outputs reflect the state being entered.
    always_comb begin
        state_d       = state_q;
        flush_if_id_d = 1'b0;
        flush_id_ex_d = 1'b0;
        pc_load_d     = 1'b0;
        pc_target_d   = pc_target_q;
        depth_d       = depth_q;
        nest_err_d    = nest_err_q;

        unique case (state_q)
            StIdle: begin
                // Interrupt wins a collision; the ERET is flushed and refetched later.
                if (int_req_i) begin
                    state_d       = StIntWait;
                    flush_if_id_d = 1'b1;
                    flush_id_ex_d = 1'b1;
                end else if (eret_i) begin
                    state_d       = StRetLoad;
                    pc_load_d     = 1'b1;
                    flush_if_id_d = 1'b1;
                    pc_target_d   = epc_i;
                end
            end
            StIntWait: begin
                state_d       = StIntLoad;
                pc_load_d     = 1'b1;
                flush_if_id_d = 1'b1;
                pc_target_d   = vec_addr;
            end
            StIntLoad: begin
                if (stall_i) begin
                    pc_load_d     = 1'b1;
                    flush_if_id_d = 1'b1;
                end else begin
                    state_d = StIdle;
                    if (depth_q == DepthMax) begin
                        nest_err_d = 1'b1;
                    end else begin
                        depth_d = depth_q + DEPTH_W'(1);
                    end
                end
            end
            StRetLoad: begin
                if (stall_i) begin
                    pc_load_d     = 1'b1;
                    flush_if_id_d = 1'b1;
                end else begin
                    state_d = StIdle;
                    if (depth_q == '0) begin
                        nest_err_d = 1'b1;
                    end else begin
                        depth_d = depth_q - DEPTH_W'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        in_handler_d = (depth_d != '0);
    end

    // State and output registers; reset abandons any pending redirect.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= StIdle;
            flush_if_id_q <= 1'b0;
            flush_id_ex_q <= 1'b0;
            pc_load_q     <= 1'b0;
            pc_target_q   <= 32'd0;
            in_handler_q  <= 1'b0;
            depth_q       <= '0;
            nest_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            flush_if_id_q <= flush_if_id_d;
            flush_id_ex_q <= flush_id_ex_d;
            pc_load_q     <= pc_load_d;
            pc_target_q   <= pc_target_d;
            in_handler_q  <= in_handler_d;
            depth_q       <= depth_d;
            nest_err_q    <= nest_err_d;
        end
    end

    assign flush_if_id_o = flush_if_id_q;
    assign flush_id_ex_o = flush_id_ex_q;
    assign pc_load_o     = pc_load_q;
    assign pc_target_o   = pc_target_q;
    assign in_handler_o  = in_handler_q;
    assign depth_o       = depth_q;
    assign nest_err_o    = nest_err_q;

endmodule

// File: tb/tb_cp0_trap_sequencer.sv
// Self-checking bench for cp0_trap_sequencer: directed cases plus randomized
// entry/return transactions against a transaction-level reference model.
module tb_cp0_trap_sequencer;

    localparam logic [31:0] VecBase  = 32'h0000_0800;
    localparam int unsigned VecShift = 4;
    localparam int unsigned DepthW   = 3;
    localparam int          DepthMax = (1 << DepthW) - 1;

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b0;
    logic              int_req_i = 1'b0;
    logic [2:0]        ipservice_i = 3'd0;
    logic              eret_i = 1'b0;
    logic [31:0]       epc_i = 32'd0;
    logic              stall_i = 1'b0;
    logic              flush_if_id_o;
    logic              flush_id_ex_o;
    logic              pc_load_o;
    logic [31:0]       pc_target_o;
    logic              in_handler_o;
    logic [DepthW-1:0] depth_o;
    logic              nest_err_o;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: nesting depth and sticky error flag.
    int depth_m = 0;
    bit nest_m  = 1'b0;

    cp0_trap_sequencer #(
        .VEC_BASE (VecBase),
        .VEC_SHIFT(VecShift),
        .DEPTH_W  (DepthW)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .int_req_i    (int_req_i),
        .ipservice_i  (ipservice_i),
        .eret_i       (eret_i),
        .epc_i        (epc_i),
        .stall_i      (stall_i),
        .flush_if_id_o(flush_if_id_o),
        .flush_id_ex_o(flush_id_ex_o),
        .pc_load_o    (pc_load_o),
        .pc_target_o  (pc_target_o),
        .in_handler_o (in_handler_o),
        .depth_o      (depth_o),
        .nest_err_o   (nest_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
        end
    endtask

    // Handler address: slot = position of highest set in-service bit plus one, 0 if none.
    function automatic logic [31:0] vec_of(input logic [2:0] ips);
        int slot;
        slot = 0;
        for (int i = 0; i < 3; i++) begin
            if (ips[i]) slot = i + 1;
        end
        return VecBase + 32'(slot * (1 << VecShift));
    endfunction

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, "_pc_load"}, 32'(pc_load_o), 32'd0);
        check_eq({tag, "_flush_if_id"}, 32'(flush_if_id_o), 32'd0);
        check_eq({tag, "_flush_id_ex"}, 32'(flush_id_ex_o), 32'd0);
        check_eq({tag, "_depth"}, 32'(depth_o), 32'(depth_m));
        check_eq({tag, "_in_handler"}, 32'(in_handler_o), 32'(depth_m != 0));
        check_eq({tag, "_nest_err"}, 32'(nest_err_o), 32'(nest_m));
    endtask

    task automatic do_entry(input logic [2:0] ips, input int nst, input logic with_eret);
        logic [31:0] exp_t;
        int          d0;
        exp_t = vec_of(ips);
        d0    = depth_m;
        next_cycle();
        int_req_i   = 1'b1;
        eret_i      = with_eret;
        epc_i       = $urandom;
        ipservice_i = 3'($urandom);
        next_cycle();
        int_req_i   = 1'b0;
        eret_i      = 1'b0;
        ipservice_i = ips;
        @(negedge clk_i);
        check_eq("ent_wait_flush_if_id", 32'(flush_if_id_o), 32'd1);
        check_eq("ent_wait_flush_id_ex", 32'(flush_id_ex_o), 32'd1);
        check_eq("ent_wait_pc_load", 32'(pc_load_o), 32'd0);
        for (int k = 0; k <= nst; k++) begin
            next_cycle();
            ipservice_i = 3'($urandom);
            stall_i     = (k < nst);
            int_req_i   = 1'($urandom);
            eret_i      = 1'($urandom);
            @(negedge clk_i);
            check_eq("ent_load_pc_load", 32'(pc_load_o), 32'd1);
            check_eq("ent_load_flush_if_id", 32'(flush_if_id_o), 32'd1);
            check_eq("ent_load_flush_id_ex", 32'(flush_id_ex_o), 32'd0);
            check_eq("ent_load_pc_target", pc_target_o, exp_t);
            check_eq("ent_load_depth", 32'(depth_o), 32'(d0));
        end
        if (depth_m == DepthMax) nest_m = 1'b1;
        else depth_m++;
        next_cycle();
        stall_i   = 1'b0;
        int_req_i = 1'b0;
        eret_i    = 1'b0;
        @(negedge clk_i);
        check_quiet("ent_done");
    endtask

    task automatic do_return(input logic [31:0] epc, input int nst);
        int d0;
        d0 = depth_m;
        next_cycle();
        eret_i = 1'b1;
        epc_i  = epc;
        for (int k = 0; k <= nst; k++) begin
            next_cycle();
            epc_i     = $urandom;
            stall_i   = (k < nst);
            int_req_i = 1'($urandom);
            eret_i    = 1'($urandom);
            @(negedge clk_i);
            check_eq("ret_load_pc_load", 32'(pc_load_o), 32'd1);
            check_eq("ret_load_flush_if_id", 32'(flush_if_id_o), 32'd1);
            check_eq("ret_load_flush_id_ex", 32'(flush_id_ex_o), 32'd0);
            check_eq("ret_load_pc_target", pc_target_o, epc);
            check_eq("ret_load_depth", 32'(depth_o), 32'(d0));
        end
        if (depth_m == 0) nest_m = 1'b1;
        else depth_m--;
        next_cycle();
        stall_i   = 1'b0;
        int_req_i = 1'b0;
        eret_i    = 1'b0;
        @(negedge clk_i);
        check_quiet("ret_done");
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            next_cycle();
            @(negedge clk_i);
            check_eq("idle_pc_load", 32'(pc_load_o), 32'd0);
        end
    endtask

    initial begin
        // Reset then idle.
        rst_ni = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        check_quiet("rst");
        check_eq("rst_pc_target", pc_target_o, 32'd0);
        rst_ni = 1'b1;
        idle_cycles(10);
        check_quiet("post_rst");

        // Directed entry, stalled entry and return.
        do_entry(3'b010, 0, 1'b0);
        do_entry(3'b010, 3, 1'b0);
        do_return(32'h0000_1234, 0);
        do_return(32'h0000_2000, 2);

        // Collision: interrupt wins, ERET dropped; spurious vector.
        do_entry(3'b111, 0, 1'b1);
        do_entry(3'b000, 1, 1'b1);
        do_return(32'h0000_0004, 0);
        do_return(32'h0000_0008, 0);

        // Underflow, then saturate with 8 entries.
        do_return(32'hFFFF_FFFC, 0);
        for (int i = 0; i < 8; i++) do_entry(3'b001, 0, 1'b0);
        for (int i = 0; i < 7; i++) do_return(32'h0000_1000 + 32'(i), 0);

        // Randomized transactions.
        for (int i = 0; i < 40; i++) begin
            idle_cycles(int'($urandom_range(0, 2)));
            if ($urandom_range(0, 1) == 1) begin
                do_entry(3'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
            end else begin
                do_return($urandom, int'($urandom_range(0, 3)));
            end
        end

        // Reset in the middle of a stalled INT_LOAD.
        next_cycle();
        int_req_i   = 1'b1;
        next_cycle();
        int_req_i   = 1'b0;
        ipservice_i = 3'b100;
        stall_i     = 1'b1;
        @(negedge clk_i);
        @(negedge clk_i);
        check_eq("mid_pre_pc_load", 32'(pc_load_o), 32'd1);
        check_eq("mid_pre_pc_target", pc_target_o, 32'h0000_0830);
        #2;
        rst_ni = 1'b0;
        #1;
        depth_m = 0;
        nest_m  = 1'b0;
        check_quiet("mid_rst");
        check_eq("mid_rst_pc_target", pc_target_o, 32'd0);
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni  = 1'b1;
        stall_i = 1'b0;
        idle_cycles(3);
        do_entry(3'b100, 0, 1'b0);
        do_return(32'h0000_5678, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, errors=%0d of %0d", n_errors, n_checks);
        $fatal(1);
    end

endmodule
